cache_control: RTL and testbench

- FSM that sequences the 2-way set-associative, write-back, write-allocate L1 cache datapath (8 sets, 128-bit lines, 9-bit tag, one LRU bit per set).
- Sits between the CPU-side request port, the cache datapath's load/select controls, and the physical-memory handshake.
- Serves hits in one cycle, writes back dirty victims, allocates lines, and keeps saturating hit/miss counters for performance debug.

---
 rtl/lc3b_types.sv | 13 +
 rtl/sat_counter.sv | 30 +++
 rtl/cache_control.sv | 157 +++++++++++++++
 tb/tb_cache_control.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b L1 cache.
// cache_state_t names the controller states for waveform and debug use; the
// controller derives its legacy-style state constants from these values so
// the two can never drift apart.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the cache hit/miss performance counters.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous, active-high; clears the count
//   inc     - increment request for this cycle
//   count_o - current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way set-associative, write-back, write-allocate L1
// cache. Hits complete in the cycle they are presented; misses write back a
// dirty victim (WRITEBACK), fill the victim way from memory (ALLOCATE) and
// then return to IDLE where the retried request hits.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   cache_read/cache_write  - CPU request, held until cache_resp
//   cache_resp              - one-cycle completion pulse to the CPU
//   way1_hit/way2_hit       - datapath tag compare results
//   LRU_out, dirty_out      - LRU bit of the set, dirty bit of the victim way
//   R_W                     - datapath select (0 = memory fill, 1 = CPU/writeback)
//   load_data_1/2           - data/tag/valid array write strobes per way
//   dirty_bit, load_dirty_1/2 - dirty array write value and strobes
//   load_LRU, LRU_in        - LRU array write strobe and value
//   pmem_read/pmem_write    - physical memory line requests
//   pmem_resp               - physical memory completion pulse
//   hit_count/miss_count    - saturating performance counters
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cache_read,
  input  logic                 cache_write,
  output logic                 cache_resp,
  input  logic                 way1_hit,
  input  logic                 way2_hit,
  input  logic                 LRU_out,
  input  logic                 dirty_out,
  output logic                 R_W,
  output logic                 load_data_1,
  output logic                 load_data_2,
  output logic                 dirty_bit,
  output logic                 load_dirty_1,
  output logic                 load_dirty_2,
  output logic                 load_LRU,
  output logic                 LRU_in,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam logic [1:0] S_IDLE      = IDLE;
  localparam logic [1:0] S_WRITEBACK = WRITEBACK;
  localparam logic [1:0] S_ALLOCATE  = ALLOCATE;

  logic [1:0] state_q, state_d;
  logic       req, hit, is_write, can_load;
  logic       hit_inc, miss_inc;

  assign req      = cache_read | cache_write;
  assign hit      = way1_hit | way2_hit;
  // A simultaneous read+write is illegal; treating it as a write keeps the
  // line consistent with whatever data the CPU presented.
  assign is_write = cache_write;
  // Array strobes are suppressed while reset is asserted so a fill that
  // completes in the reset cycle never lands a partial line.
  assign can_load = ~reset;

  assign hit_inc  = (state_q == S_IDLE) & req & hit;
  assign miss_inc = (state_q == S_IDLE) & req & ~hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output and state_d gets a default at the top of the block so
  // no path through the case leaves a value unassigned (which infers a latch).
  always_comb begin
    state_d      = state_q;
    cache_resp   = 1'b0;
    R_W          = 1'b0;
    load_data_1  = 1'b0;
    load_data_2  = 1'b0;
    dirty_bit    = 1'b0;
    load_dirty_1 = 1'b0;
    load_dirty_2 = 1'b0;
    load_LRU     = 1'b0;
    LRU_in       = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          cache_resp = 1'b1;
          load_LRU   = can_load;
          // LRU points at the way that was not just used.
          LRU_in     = way1_hit;
          if (is_write) begin
            R_W       = 1'b1;
            dirty_bit = 1'b1;
            if (way1_hit) begin
              load_data_1  = can_load;
              load_dirty_1 = can_load;
            end else begin
              load_data_2  = can_load;
              load_dirty_2 = can_load;
            end
          end
        end else if (req) begin
          state_d = dirty_out ? S_WRITEBACK : S_ALLOCATE;
        end
      end

      S_WRITEBACK: begin
        R_W        = 1'b1;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          state_d = S_ALLOCATE;
        end
      end

      S_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          dirty_bit = 1'b0;
          if (LRU_out) begin
            load_data_2  = can_load;
            load_dirty_2 = can_load;
          end else begin
            load_data_1  = can_load;
            load_dirty_1 = can_load;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (hit_inc),
    .count_o (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (miss_inc),
    .count_o (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control. A per-cycle vector table drives the
// datapath/memory inputs by hand and lists the expected control outputs and
// counter values; a second small instance with 2-bit counters covers
// saturation.
module tb_cache_control;

  // Expected-control bit positions.
  localparam logic [10:0] RESP = 11'b100_0000_0000;
  localparam logic [10:0] RW   = 11'b010_0000_0000;
  localparam logic [10:0] LD1  = 11'b001_0000_0000;
  localparam logic [10:0] LD2  = 11'b000_1000_0000;
  localparam logic [10:0] DB   = 11'b000_0100_0000;
  localparam logic [10:0] LDD1 = 11'b000_0010_0000;
  localparam logic [10:0] LDD2 = 11'b000_0001_0000;
  localparam logic [10:0] LLRU = 11'b000_0000_1000;
  localparam logic [10:0] LIN  = 11'b000_0000_0100;
  localparam logic [10:0] PMR  = 11'b000_0000_0010;
  localparam logic [10:0] PMW  = 11'b000_0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        reset, cache_read, cache_write, way1_hit, way2_hit;
  logic        LRU_out, dirty_out, pmem_resp;
  logic        cache_resp, R_W, load_data_1, load_data_2, dirty_bit;
  logic        load_dirty_1, load_dirty_2, load_LRU, LRU_in;
  logic        pmem_read, pmem_write;
  logic [15:0] hit_count, miss_count;
  logic [10:0] ctl;

  assign ctl = {cache_resp, R_W, load_data_1, load_data_2, dirty_bit,
                load_dirty_1, load_dirty_2, load_LRU, LRU_in,
                pmem_read, pmem_write};

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cache_read   (cache_read),
    .cache_write  (cache_write),
    .cache_resp   (cache_resp),
    .way1_hit     (way1_hit),
    .way2_hit     (way2_hit),
    .LRU_out      (LRU_out),
    .dirty_out    (dirty_out),
    .R_W          (R_W),
    .load_data_1  (load_data_1),
    .load_data_2  (load_data_2),
    .dirty_bit    (dirty_bit),
    .load_dirty_1 (load_dirty_1),
    .load_dirty_2 (load_dirty_2),
    .load_LRU     (load_LRU),
    .LRU_in       (LRU_in),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  // Saturation instance (2-bit counters)
  logic       s_reset, s_read, s_w1;
  logic       s_resp, s_rw, s_ld1, s_ld2, s_db, s_ldd1, s_ldd2, s_llru, s_lin;
  logic       s_pmr, s_pmw;
  logic [1:0] s_hit, s_miss;

  cache_control #(.CNT_WIDTH(2)) dut_sat (
    .clk          (clk),
    .reset        (s_reset),
    .cache_read   (s_read),
    .cache_write  (1'b0),
    .cache_resp   (s_resp),
    .way1_hit     (s_w1),
    .way2_hit     (1'b0),
    .LRU_out      (1'b0),
    .dirty_out    (1'b0),
    .R_W          (s_rw),
    .load_data_1  (s_ld1),
    .load_data_2  (s_ld2),
    .dirty_bit    (s_db),
    .load_dirty_1 (s_ldd1),
    .load_dirty_2 (s_ldd2),
    .load_LRU     (s_llru),
    .LRU_in       (s_lin),
    .pmem_read    (s_pmr),
    .pmem_write   (s_pmw),
    .pmem_resp    (1'b0),
    .hit_count    (s_hit),
    .miss_count   (s_miss)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rd, wr, w1, w2, lru, dty, presp;
    logic [10:0] ctl;
    int unsigned hc, mc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, rd, wr, w1, w2, lru, dty, presp,
                     input logic [10:0] c, input int unsigned hc, mc);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.w1 = w1; v.w2 = w2;
    v.lru = lru; v.dty = dty; v.presp = presp;
    v.ctl = c; v.hc = hc; v.mc = mc;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; cache_read = 1'b0; cache_write = 1'b0;
    way1_hit = 1'b0; way2_hit = 1'b0; LRU_out = 1'b0; dirty_out = 1'b0;
    pmem_resp = 1'b0;
    s_reset = 1'b1; s_read = 1'b0; s_w1 = 1'b0;

    //   rst rd wr w1 w2 lru dty rsp  ctl                               hit miss
    // Reset state: everything idle, counters zero.
    add(0, 0, 0, 0, 0, 0, 0, 0, 11'b0,                                  0, 0);
    // 1. Cold read @0x0040: miss, clean victim -> ALLOCATE, 5-cycle memory.
    add(0, 1, 0, 0, 0, 0, 0, 0, 11'b0,                                  0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1, PMR | LD1 | LDD1,                       0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, RESP | LLRU | LIN,                      0, 1);
    // 2. Repeat read hit.
    add(0, 1, 0, 1, 0, 1, 0, 0, RESP | LLRU | LIN,                      1, 1);
    // 3. Write @0x00C0 miss, victim way 2 clean, then write hit in way 2.
    add(0, 0, 1, 0, 0, 1, 0, 0, 11'b0,                                  2, 1);
    add(0, 0, 1, 0, 0, 1, 0, 0, PMR,                                    2, 2);
    add(0, 0, 1, 0, 0, 1, 0, 1, PMR | LD2 | LDD2,                       2, 2);
    add(0, 0, 1, 0, 1, 1, 0, 0, RESP | RW | LD2 | DB | LDD2 | LLRU,     2, 2);
    // 4a. Read @0x0140: victim way 1 clean -> straight ALLOCATE.
    add(0, 1, 0, 0, 0, 0, 0, 0, 11'b0,                                  3, 2);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    3, 3);
    add(0, 1, 0, 0, 0, 0, 0, 1, PMR | LD1 | LDD1,                       3, 3);
    add(0, 1, 0, 1, 0, 0, 0, 0, RESP | LLRU | LIN,                      3, 3);
    // 4b. Read @0x0240: victim way 2 dirty -> WRITEBACK then ALLOCATE.
    add(0, 1, 0, 0, 0, 1, 1, 0, 11'b0,                                  4, 3);
    add(0, 1, 0, 0, 0, 1, 1, 0, RW | PMW,                               4, 4);
    add(0, 1, 0, 0, 0, 1, 1, 0, RW | PMW,                               4, 4);
    add(0, 1, 0, 0, 0, 1, 1, 1, RW | PMW,                               4, 4);
    add(0, 1, 0, 0, 0, 1, 0, 0, PMR,                                    4, 4);
    add(0, 1, 0, 0, 0, 1, 0, 1, PMR | LD2 | LDD2,                       4, 4);
    add(0, 1, 0, 0, 1, 1, 0, 0, RESP | LLRU,                            4, 4);
    // pmem_resp in IDLE is ignored.
    add(0, 0, 0, 0, 0, 0, 0, 1, 11'b0,                                  5, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 11'b0,                                  5, 4);
    // Request dropped mid-fill: the fill still completes.
    add(0, 1, 0, 0, 0, 0, 0, 0, 11'b0,                                  5, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, PMR,                                    5, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, PMR | LD1 | LDD1,                       5, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 11'b0,                                  5, 5);
    // Illegal read+write with a way-1 hit behaves as a write.
    add(0, 1, 1, 1, 0, 0, 0, 0, RESP | RW | LD1 | DB | LDD1 | LLRU | LIN, 5, 5);
    // 5. Reset in ALLOCATE with pmem_resp arriving: no array write.
    add(0, 1, 0, 0, 0, 0, 0, 0, 11'b0,                                  6, 5);
    add(0, 1, 0, 0, 0, 0, 0, 0, PMR,                                    6, 6);
    add(1, 1, 0, 0, 0, 0, 0, 1, PMR,                                    6, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 11'b0,                                  0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, RESP | LLRU | LIN,                      0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 11'b0,                                  1, 0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      cache_read  = vecs[i].rd;
      cache_write = vecs[i].wr;
      way1_hit    = vecs[i].w1;
      way2_hit    = vecs[i].w2;
      LRU_out     = vecs[i].lru;
      dirty_out   = vecs[i].dty;
      pmem_resp   = vecs[i].presp;
      if (vecs[i].rd && vecs[i].wr)
        $display("note: vector %0d drives illegal read+write", i);
      #1;
      check("ctl",        i, 32'(ctl),        32'(vecs[i].ctl));
      check("hit_count",  i, 32'(hit_count),  vecs[i].hc);
      check("miss_count", i, 32'(miss_count), vecs[i].mc);
    end

    // 6. Saturation with 2-bit counters: five read hits -> 1,2,3,3,3.
    @(negedge clk);
    s_reset = 1'b0;
    #1;
    check("sat_hit_reset", 0, 32'(s_hit), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_read = 1'b1; s_w1 = 1'b1;
      #1;
      check("sat_resp", k, 32'(s_resp), 1);
      @(posedge clk);
      #1;
      check("sat_hit", k, 32'(s_hit), (k < 3) ? k + 1 : 3);
      check("sat_miss", k, 32'(s_miss), 0);
    end
    @(negedge clk);
    s_read = 1'b0; s_w1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
